// File: rtl/ice51_loader_if.sv
// rtl/ice51_loader_if.sv - code memory write port driven by the ice51 boot loader
interface ice51_loader_if #(
    parameter int ADDR_W = 10
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ice51_loader.sv
// rtl/ice51_loader.sv - UART 8N1 boot loader filling ice51 code memory, then releasing the core
// Define ICE51_PRELOAD_EN to compile out the receive path (memory preloaded externally).
module ice51_loader #(
    parameter int BAUD_DIV = 104,
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  logic           i_uart_rx,
    ice51_loader_if.master wr,
    output logic           o_done,
    output logic           o_frame_err
);

`ifdef ICE51_PRELOAD_EN
    logic done_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b1;
        end
    end

    assign wr.wr_en    = 1'b0;
    assign wr.wr_addr  = '0;
    assign wr.wr_data  = '0;
    assign o_done      = done_q;
    assign o_frame_err = 1'b0;
`else
    localparam int                CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0]     HALF_M1   = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]     FULL_M1   = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

    state_t            state_q;
    logic              rx_meta_q, rx_sync_q;
    logic              armed_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              done_q;
    logic              ferr_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Counters are loaded with N-1 so each sample lands exactly N clocks after the previous event.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!armed_q) begin
                        armed_q <= rx_sync_q;
                    end else if (!rx_sync_q) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (rx_sync_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DATA;
                        cnt_q   <= FULL_M1;
                        bit_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        cnt_q   <= FULL_M1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        // A low stop bit leaves IDLE disarmed until the line recovers.
                        armed_q <= rx_sync_q;
                        if (rx_sync_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= shift_q;
                            if (addr_q == LAST_ADDR) begin
                                state_q <= S_DONE;
                            end else begin
                                addr_q  <= addr_q + ADDR_ONE;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr.wr_en    = wr_en_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign o_done      = done_q;
    assign o_frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_ice51_loader.sv
// tb/tb_ice51_loader.sv - self-checking bench for ice51_loader
module tb_ice51_loader;
    localparam int BAUD_DIV = 104;
    localparam int MEM_SIZE = 16;
    localparam int ADDR_W   = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic rx   = 1'b1;
    logic done;
    logic ferr;

    always #5 clk = ~clk;

    ice51_loader_if #(.ADDR_W(ADDR_W)) bus ();

    ice51_loader #(
        .BAUD_DIV(BAUD_DIV),
        .MEM_SIZE(MEM_SIZE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_uart_rx  (rx),
        .wr         (bus.master),
        .o_done     (done),
        .o_frame_err(ferr)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_at = -1;

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    wr_t got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) got_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data), cyc});
        if (done === 1'b1 && done_at < 0) done_at = cyc;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nrst = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        got_q.delete();
        done_at = -1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BAUD_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok, output int t0);
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_ok);
        rx = 1'b1;
        if (!stop_ok) send_bit(1'b1);
    endtask

    typedef struct {
        bit         rst;
        bit         glitch;
        logic [7:0] d;
        bit         stop_ok;
        int         exp_n;
        int         exp_addr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

`ifdef ICE51_PRELOAD_EN
    initial begin
        int t0;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_done_in_reset", int'(done), 0);
        nrst = 1'b1;
        @(negedge clk);
        check("pre_done_first_clk", int'(done), 1);
        send_byte(8'hA5, 1'b1, t0);
        send_byte(8'h81, 1'b0, t0);
        check("pre_no_wr", got_q.size(), 0);
        check("pre_ferr", int'(ferr), 0);
        check("pre_done_sticky", int'(done), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
`else
    initial begin
        int         t0;
        int         n0;
        int         m_addr;
        int         m_ferr;
        logic [7:0] d;
        logic       ok;
        wr_t        exp_q[$];

        vecs[0] = '{1'b1, 1'b0, 8'h81, 1'b0, 0, 0, 1};
        vecs[1] = '{1'b0, 1'b0, 8'h42, 1'b1, 1, 0, 1};
        vecs[2] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1, 1, 1};
        vecs[3] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1, 0, 0};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 1'b0, 0, 0, 1};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1, 2, 1};

        // Reset values and single-byte latency
        do_reset();
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'(bus.wr_data), 0);
        check("rst_done", int'(done), 0);
        check("rst_ferr", int'(ferr), 0);
        send_byte(8'hA5, 1'b1, t0);
        check("single_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("single_addr", got_q[0].addr, 0);
            check("single_data", got_q[0].data, 8'hA5);
            check_rng("single_latency", got_q[0].at - t0, 990, 992);
        end
        check("single_done", int'(done), 0);

        // Table-driven sequences: frame error, glitch, address progression
        foreach (vecs[v]) begin
            if (vecs[v].rst) do_reset();
            if (vecs[v].glitch) begin
                rx = 1'b0;
                repeat (30) @(posedge clk);
                #1;
                rx = 1'b1;
                repeat (200) @(posedge clk);
                #1;
                check("glitch_no_wr", got_q.size(), 0);
            end
            n0 = got_q.size();
            send_byte(vecs[v].d, vecs[v].stop_ok, t0);
            repeat (20) @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", v), got_q.size() - n0, vecs[v].exp_n);
            if (vecs[v].exp_n == 1 && got_q.size() > n0) begin
                check($sformatf("vec%0d_addr", v), got_q[n0].addr, vecs[v].exp_addr);
                check($sformatf("vec%0d_data", v), got_q[n0].data, int'(vecs[v].d));
            end
            check($sformatf("vec%0d_ferr", v), int'(ferr), vecs[v].exp_ferr);
            check($sformatf("vec%0d_done", v), int'(done), 0);
        end

        // Reset asserted during data bit 4 of byte 5
        do_reset();
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b1, t0);
        check("midrst_pre_count", got_q.size(), 4);
        d = 8'hC7;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (BAUD_DIV / 2) @(posedge clk);
        #1;
        nrst = 1'b0;
        #2;
        check("midrst_wr_en", int'(bus.wr_en), 0);
        check("midrst_wr_addr", int'(bus.wr_addr), 0);
        check("midrst_wr_data", int'(bus.wr_data), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_ferr", int'(ferr), 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        nrst = 1'b1;
        got_q.delete();
        repeat (5) @(posedge clk);
        #1;
        send_byte(8'h99, 1'b1, t0);
        check("midrst_after_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("midrst_after_addr", got_q[0].addr, 0);
            check("midrst_after_data", got_q[0].data, 8'h99);
        end

        // Randomized full load, back-to-back, against the address/flag model
        do_reset();
        m_addr = 0;
        m_ferr = 0;
        while (m_addr < MEM_SIZE) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_byte(d, ok, t0);
            if (ok) begin
                exp_q.push_back('{m_addr, int'(d), 0});
                m_addr++;
            end else begin
                m_ferr = 1;
            end
        end
        repeat (10) @(posedge clk);
        #1;
        check("load_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
                check($sformatf("load_wr%0d_addr", i), got_q[i].addr, exp_q[i].addr);
                check($sformatf("load_wr%0d_data", i), got_q[i].data, exp_q[i].data);
            end else begin
                n_cmp++;
            end
        end
        check("load_ferr", int'(ferr), m_ferr);
        check("load_done", int'(done), 1);
        if (got_q.size() > 0) check("load_done_delay", done_at - got_q[got_q.size() - 1].at, 1);
        n0 = got_q.size();
        send_byte(8'h55, 1'b1, t0);
        repeat (10) @(posedge clk);
        #1;
        check("post_done_no_wr", got_q.size() - n0, 0);
        check("post_done_sticky", int'(done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
`endif

endmodule
